bcd_sevenseg_scan: RTL and testbench
====================================

# bcd_sevenseg_scan

Multiplexed seven-segment display driver that consumes packed BCD digits from the BCD counter chain and drives a common-anode/cathode LED display. It double-buffers the digit word so display updates occur only on frame boundaries, scans one digit per slot with a ghosting-blank interval, and optionally suppresses leading zeros. It sits directly downstream of the BCD counters and drives the board display pins.

## Interface
- NDIG, 4: number of digits scanned (1..8).
- REFRESH_DIV, 50000: clk cycles per digit slot (>= 2).
- BLANK, 2: cycles at the start of each slot with all anodes off (1..REFRESH_DIV-1).
- ACTIVE_LOW, 1: 1 = seg/dp/an active-low; 0 = active-high.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bcd_in  in  4*NDIG  packed digits; digit k = bcd_in[4k+3:4k], digit 0 least significant.
- dp_in  in  NDIG  decimal point request per digit.
- load  in  1  capture strobe for bcd_in/dp_in.
- blank_lz  in  1  leading-zero blanking enable (sampled every cycle).
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- an  out  NDIG  digit enables; an[k] drives digit k.
- frame_done  out  1  one-cycle pulse at start of each new frame.

## Operation
- State: prescaler pre (0..REFRESH_DIV-1), digit index idx (0..NDIG-1), shadow reg shd, display reg disp (4*NDIG+NDIG bits each, digits plus dp).
- pre increments every cycle; at REFRESH_DIV-1 wraps to 0 and idx advances; idx NDIG-1 wraps to 0.
- load=1: shd <= {dp_in, bcd_in} on that edge; later loads overwrite earlier ones.
- Frame wrap edge (pre=REFRESH_DIV-1, idx=NDIG-1): disp <= shd; if load=1 on that same edge, disp <= {dp_in, bcd_in} directly (new value wins).
- Blank phase (pre < BLANK): all an, seg, dp inactive.
- Active phase: an[idx] active, others inactive; seg = decode(disp digit idx); dp = disp dp bit idx.
- Decode (active-high sense): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; any nibble 10-15 = 40 (dash, g only). ACTIVE_LOW inverts.
- Leading-zero blanking (blank_lz=1): digit k > 0 blanked if it and all digits above it are 0. Digit 0 never blanked. Blanked slot: an, seg, dp all inactive for the whole slot.
- frame_done: high exactly one cycle, the cycle after each frame wrap edge (pre=0, idx=0); never asserted on the first frame after reset.

## Timing
- Outputs are registers updated on the same edge as pre/idx; they always reflect the current (pre, idx, disp, blank_lz) with no further latency.
- Slot length REFRESH_DIV cycles; frame length NDIG*REFRESH_DIV cycles.
- Reset (async): pre=0, idx=0, shd=0, disp=0, frame_done=0, an/seg/dp inactive (consistent with blank phase). First active digit is digit 0 at pre=BLANK.
- load mid-frame: no visible change until the next frame; no tearing within a frame.
- rst mid-frame: immediate return to reset state; pending shd contents discarded.
- blank_lz change takes effect on the next edge, including mid-slot.

## Test plan
(NDIG=4, REFRESH_DIV=4, BLANK=1, ACTIVE_LOW=1; frame = 16 cycles.)
- Reset then release -> during rst an=1111, seg=7F, dp=1, frame_done=0; first edge after release pre=1, an=1110, seg=40 ("0").
- load bcd_in=0x1234 at cycle 5 -> current frame still shows 0s; after wrap frame_done pulses once; digit0 seg=19, digit3 slot an=0111 seg=79.
- blank_lz=1, disp=0x0050 -> digits 3,2 slots an=1111 seg=7F; digit1 seg=12; digit0 seg=40; disp=0x0000 -> only digit0 lit, seg=40.
- Nibble 0xA in digit 2, dp_in=0100 -> digit2 slot seg=3F, dp=0; other slots dp=1.
- load asserted on the frame wrap edge with 0x9876 (shd holds 0x1111) -> next frame shows 9876, never 1111.
- rst pulsed while idx=2, pre=2 -> outputs inactive immediately; after release scan restarts at digit 0, display 0000, no frame_done until a full 16-cycle frame completes.

Source files
------------

// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan: double-buffered multiplexed seven-segment driver with ghost blanking and leading-zero suppression
module bcd_sevenseg_scan #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK       = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              load,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int DW = 5 * NDIG;
    localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [6:0]      SEG_OFF = ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [NDIG-1:0] AN_OFF  = ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic            DP_OFF  = ACTIVE_LOW != 0;
    logic [PW-1:0]   pre, pre_n;
    logic [IW-1:0]   idx, idx_n;
    logic [DW-1:0]   shd, disp, disp_n;
    logic            slot_end, wrap, all_zero, lit;
    logic [3:0]      dig [NDIG];
    logic [NDIG-1:0] hide;
    logic [6:0]      seg_n;
    logic [NDIG-1:0] an_n;
    logic            dp_n;
    // next scan position and display word; outputs are derived from these so they carry no extra latency
    always_comb begin
        slot_end = pre == PW'(REFRESH_DIV - 1);
        wrap     = slot_end && idx == IW'(NDIG - 1);
        pre_n    = slot_end ? '0 : pre + 1'b1;
        idx_n    = slot_end ? (wrap ? '0 : idx + 1'b1) : idx;
        disp_n   = wrap ? (load ? {dp_in, bcd_in} : shd) : disp;
        all_zero = 1'b1;
        hide     = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            dig[k]   = disp_n[4*k +: 4];
            all_zero = all_zero && dig[k] == 4'd0;
            hide[k]  = blank_lz && k > 0 && all_zero;
        end
        lit   = pre_n >= PW'(BLANK) && !hide[idx_n];
        seg_n = lit ? LUT[dig[idx_n]] ^ SEG_OFF : SEG_OFF;
        an_n  = lit ? (NDIG'(1) << idx_n) ^ AN_OFF : AN_OFF;
        dp_n  = lit ? disp_n[4*NDIG + int'(idx_n)] ^ DP_OFF : DP_OFF;
    end
    // scan counters, double buffer and registered pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre        <= '0;
            idx        <= '0;
            shd        <= '0;
            disp       <= '0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            dp         <= DP_OFF;
        end else begin
            pre        <= pre_n;
            idx        <= idx_n;
            shd        <= load ? {dp_in, bcd_in} : shd;
            disp       <= disp_n;
            frame_done <= wrap;
            seg        <= seg_n;
            an         <= an_n;
            dp         <= dp_n;
        end
    end
endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// tb_bcd_sevenseg_scan: directed checks of scan timing, buffering, decode and blanking
module tb_bcd_sevenseg_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    int          n = 0;
    int          cmp = 0;
    int          bad = 0;

    bcd_sevenseg_scan #(.NDIG(4), .REFRESH_DIV(4), .BLANK(1), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic go(input int target);
        while (n < target) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
        cmp++;
        assert (an === a && seg === s && dp === d && frame_done === f) else begin
            bad++;
            $error("FAIL %s: got an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=%b",
                   tag, an, seg, dp, frame_done, a, s, d, f);
        end
    endtask

    task automatic fdchk(input string tag, input logic f);
        cmp++;
        assert (frame_done === f) else begin
            bad++;
            $error("FAIL %s: n=%0d got fd=%b, expected fd=%b", tag, n, frame_done, f);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;
        n = 0;
        go(1);   chk("first_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        go(4);   chk("blank_slot1", 4'hF, 7'h7F, 1'b1, 1'b0);
        bcd_in = 16'h1234; load = 1'b1;
        go(5);   load = 1'b0;
        chk("no_tear_d1", 4'hD, 7'h40, 1'b1, 1'b0);
        go(15);  chk("old_d3", 4'h7, 7'h40, 1'b1, 1'b0);
        go(16);  chk("fd_pulse", 4'hF, 7'h7F, 1'b1, 1'b1);
        go(17);  chk("new_d0_4", 4'hE, 7'h19, 1'b1, 1'b0);
        go(21);  chk("new_d1_3", 4'hD, 7'h30, 1'b1, 1'b0);
        go(29);  chk("new_d3_1", 4'h7, 7'h79, 1'b1, 1'b0);
        go(30);  bcd_in = 16'h0050; load = 1'b1;
        go(31);  load = 1'b0; blank_lz = 1'b1;
        go(32);  chk("fd_frame3", 4'hF, 7'h7F, 1'b1, 1'b1);
        go(33);  chk("lz_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        go(37);  chk("lz_d1_5", 4'hD, 7'h12, 1'b1, 1'b0);
        go(41);  chk("lz_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
        go(45);  chk("lz_d3", 4'hF, 7'h7F, 1'b1, 1'b0);
        bcd_in = 16'h0000; load = 1'b1;
        go(46);  load = 1'b0;
        go(49);  chk("zero_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        go(53);  chk("zero_d1", 4'hF, 7'h7F, 1'b1, 1'b0);
        blank_lz = 1'b0;
        go(54);  chk("lz_off_midslot", 4'hD, 7'h40, 1'b1, 1'b0);
        bcd_in = 16'h0A00; dp_in = 4'b0100; load = 1'b1;
        go(55);  load = 1'b0; dp_in = 4'b0000;
        go(65);  chk("dash_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        go(73);  chk("dash_d2", 4'hB, 7'h3F, 1'b0, 1'b0);
        go(77);  chk("dash_d3", 4'h7, 7'h40, 1'b1, 1'b0);
        go(81);  bcd_in = 16'h1111; load = 1'b1;
        go(82);  load = 1'b0;
        go(95);  chk("pre_wrap_d3", 4'h7, 7'h40, 1'b1, 1'b0);
        bcd_in = 16'h9876; load = 1'b1;
        go(96);  load = 1'b0;
        chk("wrap_fd", 4'hF, 7'h7F, 1'b1, 1'b1);
        go(97);  chk("wrap_d0_6", 4'hE, 7'h02, 1'b1, 1'b0);
        go(101); chk("wrap_d1_7", 4'hD, 7'h78, 1'b1, 1'b0);
        go(105); chk("wrap_d2_8", 4'hB, 7'h00, 1'b1, 1'b0);
        go(106);
        rst = 1'b1;
        #1;
        chk("rst_async", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        go(1);   chk("rst_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        for (int i = 2; i < 16; i++) begin
            go(i);
            fdchk("no_early_fd", 1'b0);
        end
        go(16);  fdchk("fd_after_rst", 1'b1);
        go(17);  chk("shd_cleared", 4'hE, 7'h40, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
